// File: rtl/gte_wb_regbank.sv
// GTE register bank: compute-side FIFOs and accumulators plus the CPU read/write port.
// Compute strobes override CPU writes to the same register; reads return pre-edge values.
package gte_wb_regbank_pkg;
   typedef struct packed {
      logic [15:0]       otz;
      logic [3:0][15:0]  ir;
      logic [2:0][31:0]  sxy;
      logic [3:0][15:0]  sz;
      logic [2:0][31:0]  rgb;
      logic [3:0][31:0]  mac;
      logic [31:0]       flag;
   } regs_t;
endpackage

module gte_wb_regbank
   import gte_wb_regbank_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_instrStart,
   input  logic        i_wrMAC0,
   input  logic [31:0] i_MAC0,
   input  logic [2:0]  i_wrMAC13,
   input  logic [31:0] i_MAC13,
   input  logic        i_wrIR0,
   input  logic [15:0] i_IR0,
   input  logic [2:0]  i_wrIR13,
   input  logic [15:0] i_IR13,
   input  logic        i_pushX,
   input  logic        i_pushY,
   input  logic [15:0] i_XYV,
   input  logic        i_pushZ,
   input  logic [15:0] i_OTZV,
   input  logic        i_wrOTZ,
   input  logic [2:0]  i_wrCol,
   input  logic [7:0]  i_colV,
   input  logic [7:0]  i_CODE,
   input  logic [18:0] i_updateFlags,
   input  logic        i_busy,
   input  logic        i_cpuWr,
   input  logic [5:0]  i_cpuAdr,
   input  logic [31:0] i_cpuData,
   input  logic        i_cpuRd,
   output logic [31:0] o_rdData,
   output logic        o_rdValid,
   output logic        o_rdHit,
   output regs_t       o_regs
);

   logic [15:0]       otz_r;
   logic [3:0][15:0]  ir_r;
   logic [2:0][31:0]  sxy_r;
   logic [3:0][15:0]  sz_r;
   logic [2:0][31:0]  rgb_r;
   logic [3:0][31:0]  mac_r;
   logic [18:0]       flag_r;
   logic [15:0]       pend_x_r;
   logic [7:0]        pend_r_r;
   logic [7:0]        pend_g_r;
   logic [31:0]       rd_data_r;
   logic              rd_valid_r;
   logic              rd_hit_r;

   logic              cpu_wr_s;
   logic [15:0]       x_in_s;
   logic [7:0]        r_in_s;
   logic [7:0]        g_in_s;
   logic [31:0]       flag_full_s;
   logic [31:0]       rd_mux_s;
   logic              hit_s;

   // Same-cycle strobes feed the FIFO word directly instead of the stale pending byte.
   assign cpu_wr_s    = i_cpuWr & ~i_busy;
   assign x_in_s      = i_pushX    ? i_XYV  : pend_x_r;
   assign r_in_s      = i_wrCol[0] ? i_colV : pend_r_r;
   assign g_in_s      = i_wrCol[1] ? i_colV : pend_g_r;
   assign flag_full_s = {(|flag_r[18:11]) | (|flag_r[6:1]), flag_r, 12'd0};

   // Register state: CPU write first, compute strobes assigned later so they win.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         otz_r    <= 16'd0;
         ir_r     <= {4{16'd0}};
         sxy_r    <= {3{32'd0}};
         sz_r     <= {4{16'd0}};
         rgb_r    <= {3{32'd0}};
         mac_r    <= {4{32'd0}};
         flag_r   <= 19'd0;
         pend_x_r <= 16'd0;
         pend_r_r <= 8'd0;
         pend_g_r <= 8'd0;
      end else begin
         if (cpu_wr_s) begin
            case (i_cpuAdr)
               6'd7:                          otz_r <= i_cpuData[15:0];
               6'd8, 6'd9, 6'd10, 6'd11:      ir_r[i_cpuAdr[1:0]] <= i_cpuData[15:0];
               6'd12, 6'd13, 6'd14:           sxy_r[i_cpuAdr[1:0]] <= i_cpuData;
               6'd15:                         sxy_r <= {i_cpuData, sxy_r[2], sxy_r[1]};
               6'd16, 6'd17, 6'd18, 6'd19:    sz_r[i_cpuAdr[1:0]] <= i_cpuData[15:0];
               6'd20, 6'd21, 6'd22:           rgb_r[i_cpuAdr[1:0]] <= i_cpuData;
               6'd24, 6'd25, 6'd26, 6'd27:    mac_r[i_cpuAdr[1:0]] <= i_cpuData;
               6'd63:                         flag_r <= i_cpuData[30:12];
               default: ;
            endcase
         end
         if (i_wrMAC0)     mac_r[0] <= i_MAC0;
         if (i_wrMAC13[0]) mac_r[1] <= i_MAC13;
         if (i_wrMAC13[1]) mac_r[2] <= i_MAC13;
         if (i_wrMAC13[2]) mac_r[3] <= i_MAC13;
         if (i_wrIR0)      ir_r[0]  <= i_IR0;
         if (i_wrIR13[0])  ir_r[1]  <= i_IR13;
         if (i_wrIR13[1])  ir_r[2]  <= i_IR13;
         if (i_wrIR13[2])  ir_r[3]  <= i_IR13;
         if (i_pushX)      pend_x_r <= i_XYV;
         if (i_pushY)      sxy_r    <= {i_XYV, x_in_s, sxy_r[2], sxy_r[1]};
         if (i_pushZ)      sz_r     <= {i_OTZV, sz_r[3], sz_r[2], sz_r[1]};
         if (i_wrOTZ)      otz_r    <= i_OTZV;
         if (i_wrCol[0])   pend_r_r <= i_colV;
         if (i_wrCol[1])   pend_g_r <= i_colV;
         if (i_wrCol[2])   rgb_r    <= {i_CODE, i_colV, g_in_s, r_in_s, rgb_r[2], rgb_r[1]};
         if (i_instrStart)          flag_r <= i_updateFlags;
         else if (|i_updateFlags)   flag_r <= flag_r | i_updateFlags;
      end
   end

   // Read mux with per-field extension; unowned addresses read as zero.
   always_comb begin
      rd_mux_s = 32'd0;
      hit_s    = 1'b1;
      case (i_cpuAdr)
         6'd7:                       rd_mux_s = {16'd0, otz_r};
         6'd8, 6'd9, 6'd10, 6'd11:   rd_mux_s = {{16{ir_r[i_cpuAdr[1:0]][15]}}, ir_r[i_cpuAdr[1:0]]};
         6'd12, 6'd13, 6'd14:        rd_mux_s = sxy_r[i_cpuAdr[1:0]];
         6'd15:                      rd_mux_s = sxy_r[2];
         6'd16, 6'd17, 6'd18, 6'd19: rd_mux_s = {16'd0, sz_r[i_cpuAdr[1:0]]};
         6'd20, 6'd21, 6'd22:        rd_mux_s = rgb_r[i_cpuAdr[1:0]];
         6'd24, 6'd25, 6'd26, 6'd27: rd_mux_s = mac_r[i_cpuAdr[1:0]];
         6'd63:                      rd_mux_s = flag_full_s;
         default: begin
            rd_mux_s = 32'd0;
            hit_s    = 1'b0;
         end
      endcase
   end

   // Registered read response, one cycle after the request.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_data_r  <= 32'd0;
         rd_valid_r <= 1'b0;
         rd_hit_r   <= 1'b0;
      end else begin
         rd_data_r  <= i_cpuRd ? rd_mux_s : 32'd0;
         rd_valid_r <= i_cpuRd;
         rd_hit_r   <= i_cpuRd & hit_s;
      end
   end

   assign o_rdData  = rd_data_r;
   assign o_rdValid = rd_valid_r;
   assign o_rdHit   = rd_hit_r;

   // Parallel register view for the compute path.
   always_comb begin
      o_regs.otz  = otz_r;
      o_regs.ir   = ir_r;
      o_regs.sxy  = sxy_r;
      o_regs.sz   = sz_r;
      o_regs.rgb  = rgb_r;
      o_regs.mac  = mac_r;
      o_regs.flag = flag_full_s;
   end

endmodule

// File: tb/tb_gte_wb_regbank.sv
// Randomised and directed bench for gte_wb_regbank against an address-indexed register model.
module tb_gte_wb_regbank;
   import gte_wb_regbank_pkg::*;

   logic        clk = 1'b0;
   logic        rst, instr_start, wr_mac0, wr_ir0, push_x, push_y, push_z, wr_otz, busy, cpu_wr, cpu_rd;
   logic [31:0] mac0, mac13, cpu_data;
   logic [2:0]  wr_mac13, wr_ir13, wr_col;
   logic [15:0] ir0, ir13, xyv, otzv;
   logic [7:0]  col_v, code;
   logic [18:0] upd;
   logic [5:0]  cpu_adr;
   logic [31:0] rd_data;
   logic        rd_valid, rd_hit;
   regs_t       regs;

   int n_pass = 0;
   int n_total = 0;

   // Model: architectural value per CPU address, plus pending bytes and expected read response.
   logic [31:0] m [64];
   logic [15:0] m_px;
   logic [7:0]  m_pr, m_pg;
   logic [31:0] e_data;
   logic        e_valid, e_hit;

   gte_wb_regbank dut (
      .i_clk(clk), .i_rst(rst), .i_instrStart(instr_start),
      .i_wrMAC0(wr_mac0), .i_MAC0(mac0), .i_wrMAC13(wr_mac13), .i_MAC13(mac13),
      .i_wrIR0(wr_ir0), .i_IR0(ir0), .i_wrIR13(wr_ir13), .i_IR13(ir13),
      .i_pushX(push_x), .i_pushY(push_y), .i_XYV(xyv),
      .i_pushZ(push_z), .i_OTZV(otzv), .i_wrOTZ(wr_otz),
      .i_wrCol(wr_col), .i_colV(col_v), .i_CODE(code), .i_updateFlags(upd),
      .i_busy(busy), .i_cpuWr(cpu_wr), .i_cpuAdr(cpu_adr), .i_cpuData(cpu_data), .i_cpuRd(cpu_rd),
      .o_rdData(rd_data), .o_rdValid(rd_valid), .o_rdHit(rd_hit), .o_regs(regs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic owned(input int a);
      return (a >= 7 && a <= 22) || (a >= 24 && a <= 27) || a == 63;
   endfunction

   function automatic logic [31:0] mread(input int a);
      logic [31:0] v;
      v = 32'd0;
      if (a == 7 || (a >= 16 && a <= 19)) v = {16'd0, m[a][15:0]};
      else if (a >= 8 && a <= 11) v = {{16{m[a][15]}}, m[a][15:0]};
      else if (a == 15) v = m[14];
      else if ((a >= 12 && a <= 14) || (a >= 20 && a <= 22) || (a >= 24 && a <= 27)) v = m[a];
      else if (a == 63) begin
         v = m[63] & 32'h7FFF_F000;
         v[31] = (|v[30:23]) | (|v[18:13]);
      end
      return v;
   endfunction

   task automatic model_step();
      logic [31:0] n [64];
      logic [31:0] d, u;
      logic [15:0] xin;
      logic [7:0]  rin, gin;
      int a;
      a = int'(cpu_adr);
      d = cpu_data;
      u = {1'b0, upd, 12'd0};
      n = m;
      e_valid = cpu_rd;
      e_hit   = cpu_rd && owned(a);
      e_data  = (cpu_rd && owned(a)) ? mread(a) : 32'd0;
      if (rst) begin
         foreach (n[i]) n[i] = 32'd0;
         m_px = 16'd0; m_pr = 8'd0; m_pg = 8'd0;
         e_valid = 1'b0; e_hit = 1'b0; e_data = 32'd0;
      end else begin
         if (cpu_wr && !busy) begin
            if (a == 7 && !wr_otz) n[a] = d & 32'hFFFF;
            if (a == 8 && !wr_ir0) n[a] = d & 32'hFFFF;
            if (a >= 9 && a <= 11 && !wr_ir13[a-9]) n[a] = d & 32'hFFFF;
            if (a >= 12 && a <= 14 && !push_y) n[a] = d;
            if (a == 15 && !push_y) begin n[12] = m[13]; n[13] = m[14]; n[14] = d; end
            if (a >= 16 && a <= 19 && !push_z) n[a] = d & 32'hFFFF;
            if (a >= 20 && a <= 22 && !wr_col[2]) n[a] = d;
            if (a == 24 && !wr_mac0) n[a] = d;
            if (a >= 25 && a <= 27 && !wr_mac13[a-25]) n[a] = d;
            if (a == 63 && !instr_start && upd == 19'd0) n[a] = d & 32'h7FFF_F000;
         end
         if (wr_mac0) n[24] = mac0;
         if (wr_ir0)  n[8]  = {16'd0, ir0};
         for (int k = 0; k < 3; k++) begin
            if (wr_mac13[k]) n[25+k] = mac13;
            if (wr_ir13[k])  n[9+k]  = {16'd0, ir13};
         end
         xin = push_x ? xyv : m_px;
         if (push_x) m_px = xyv;
         if (push_y) begin n[12] = m[13]; n[13] = m[14]; n[14] = {xyv, xin}; end
         if (push_z) begin n[16] = m[17]; n[17] = m[18]; n[18] = m[19]; n[19] = {16'd0, otzv}; end
         if (wr_otz) n[7] = {16'd0, otzv};
         rin = wr_col[0] ? col_v : m_pr;
         gin = wr_col[1] ? col_v : m_pg;
         if (wr_col[0]) m_pr = col_v;
         if (wr_col[1]) m_pg = col_v;
         if (wr_col[2]) begin n[20] = m[21]; n[21] = m[22]; n[22] = {code, col_v, gin, rin}; end
         n[63] = instr_start ? u : (n[63] | u);
      end
      m = n;
   endtask

   // Advance the model on every edge and compare all outputs shortly after.
   always @(posedge clk) begin
      model_step();
      #1;
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_valid});
      chk("rd_hit", {31'd0, rd_hit}, {31'd0, e_hit});
      chk("rd_data", rd_data, e_data);
      chk("otz", {16'd0, regs.otz}, {16'd0, m[7][15:0]});
      chk("flag", regs.flag, mread(63));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ir%0d", i), {16'd0, regs.ir[i]}, {16'd0, m[8+i][15:0]});
         chk($sformatf("sz%0d", i), {16'd0, regs.sz[i]}, {16'd0, m[16+i][15:0]});
         chk($sformatf("mac%0d", i), regs.mac[i], m[24+i]);
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("sxy%0d", i), regs.sxy[i], m[12+i]);
         chk($sformatf("rgb%0d", i), regs.rgb[i], m[20+i]);
      end
   end

   task automatic idle();
      rst = 1'b0; instr_start = 1'b0; wr_mac0 = 1'b0; wr_ir0 = 1'b0; push_x = 1'b0; push_y = 1'b0;
      push_z = 1'b0; wr_otz = 1'b0; busy = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
      mac0 = 32'd0; mac13 = 32'd0; cpu_data = 32'd0; wr_mac13 = 3'd0; wr_ir13 = 3'd0; wr_col = 3'd0;
      ir0 = 16'd0; ir13 = 16'd0; xyv = 16'd0; otzv = 16'd0; col_v = 8'd0; code = 8'd0;
      upd = 19'd0; cpu_adr = 6'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      idle();
   endtask

   task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v, input logic [31:0] exp);
      chk(name, dut_v, exp);
      chk({"model_", name}, mdl_v, exp);
   endtask

   task automatic randomize_inputs();
      logic [31:0] r;
      int a;
      idle();
      r = $urandom;
      rst         = ($urandom_range(0, 199) == 0);
      instr_start = ($urandom_range(0, 15) == 0);
      upd         = ($urandom_range(0, 3) == 0) ? r[18:0] & (19'd1 << $urandom_range(0, 18)) : 19'd0;
      wr_mac0     = ($urandom_range(0, 7) == 0);
      mac0        = $urandom;
      wr_mac13    = ($urandom_range(0, 5) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'd0;
      mac13       = $urandom;
      wr_ir0      = ($urandom_range(0, 7) == 0);
      r = $urandom;
      ir0         = r[15:0];
      ir13        = r[31:16];
      wr_ir13     = ($urandom_range(0, 5) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'd0;
      push_x      = ($urandom_range(0, 3) == 0);
      push_y      = ($urandom_range(0, 3) == 0);
      push_z      = ($urandom_range(0, 4) == 0);
      wr_otz      = ($urandom_range(0, 6) == 0);
      r = $urandom;
      xyv         = r[15:0];
      otzv        = r[31:16];
      case ($urandom_range(0, 5))
         0: wr_col = 3'b001;
         1: wr_col = 3'b010;
         2: wr_col = 3'b100;
         3: wr_col = 3'b111;
         default: wr_col = 3'b000;
      endcase
      r = $urandom;
      col_v       = r[7:0];
      code        = r[15:8];
      busy        = ($urandom_range(0, 3) == 0);
      cpu_wr      = ($urandom_range(0, 2) == 0);
      cpu_rd      = ($urandom_range(0, 1) == 0);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(7, 28);
      if ($urandom_range(0, 9) == 0) a = 63;
      cpu_adr     = 6'(a);
      cpu_data    = $urandom;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();
      lit("rst_flag", regs.flag, mread(63), 32'd0);
      lit("rst_valid", {31'd0, rd_valid}, {31'd0, e_valid}, 32'd0);

      cpu_rd = 1'b1; cpu_adr = 6'd63;
      step();
      lit("rd63_valid", {31'd0, rd_valid}, {31'd0, e_valid}, 32'd1);
      lit("rd63_data", rd_data, e_data, 32'd0);
      step();
      lit("rd63_valid_drop", {31'd0, rd_valid}, {31'd0, e_valid}, 32'd0);

      for (int i = 1; i <= 4; i++) begin
         push_x = 1'b1; xyv = 16'(i);
         step();
         push_y = 1'b1; xyv = 16'(32'h10 + i - 1);
         step();
      end
      lit("sxy0_pairs", regs.sxy[0], m[12], 32'h0011_0002);
      lit("sxy2_pairs", regs.sxy[2], m[14], 32'h0013_0004);

      upd = 19'd1 << 2;
      step();
      upd = 19'd1 << 10;
      step();
      lit("flag_acc", regs.flag, mread(63), 32'h8040_4000);
      instr_start = 1'b1;
      step();
      lit("flag_clr", regs.flag, mread(63), 32'd0);

      cpu_wr = 1'b1; cpu_adr = 6'd9; cpu_data = 32'h0000_F000;
      step();
      cpu_rd = 1'b1; cpu_adr = 6'd9;
      step();
      lit("ir1_sext", rd_data, e_data, 32'hFFFF_F000);

      cpu_wr = 1'b1; cpu_adr = 6'd15; cpu_data = 32'h1234_5678;
      step();
      lit("sxyp_sxy2", regs.sxy[2], m[14], 32'h1234_5678);
      lit("sxyp_sxy1", regs.sxy[1], m[13], 32'h0013_0004);
      cpu_rd = 1'b1; cpu_adr = 6'd15;
      step();
      lit("sxyp_rd", rd_data, e_data, 32'h1234_5678);

      busy = 1'b1; cpu_wr = 1'b1; cpu_adr = 6'd25; cpu_data = 32'd5;
      step();
      lit("busy_mac1", regs.mac[1], m[25], 32'd0);
      wr_mac13 = 3'b001; mac13 = 32'd7; cpu_wr = 1'b1; cpu_adr = 6'd25; cpu_data = 32'd5;
      step();
      lit("prio_mac1", regs.mac[1], m[25], 32'd7);

      wr_col = 3'b001; col_v = 8'h11;
      step();
      wr_col = 3'b010; col_v = 8'h22;
      step();
      wr_col = 3'b100; col_v = 8'h33; code = 8'h2C;
      step();
      lit("rgb2", regs.rgb[2], m[22], 32'h2C33_2211);
      push_z = 1'b1; otzv = 16'hFFFF;
      step();
      lit("sz3", {16'd0, regs.sz[3]}, m[19], 32'h0000_FFFF);
      cpu_rd = 1'b1; cpu_adr = 6'd19;
      step();
      lit("sz3_rd", rd_data, e_data, 32'h0000_FFFF);

      push_x = 1'b1; push_y = 1'b1; xyv = 16'hABCD;
      step();
      lit("xy_same", regs.sxy[2], m[14], 32'hABCD_ABCD);
      wr_col = 3'b111; col_v = 8'h5A; code = 8'h01;
      step();
      lit("rgb_same", regs.rgb[2], m[22], 32'h015A_5A5A);
      upd = 19'd1 << 18;
      step();
      instr_start = 1'b1; upd = 19'd1;
      step();
      lit("flag_start_upd", regs.flag, mread(63), 32'h0000_1000);
      cpu_rd = 1'b1; cpu_adr = 6'd23;
      step();
      lit("unowned_hit", {31'd0, rd_hit}, {31'd0, e_hit}, 32'd0);
      lit("unowned_data", rd_data, e_data, 32'd0);

      rst = 1'b1; push_y = 1'b1; xyv = 16'h7777; wr_mac0 = 1'b1; mac0 = 32'h55; cpu_rd = 1'b1; cpu_adr = 6'd24;
      step();
      lit("rst_sxy2", regs.sxy[2], m[14], 32'd0);
      lit("rst_mac0", regs.mac[0], m[24], 32'd0);
      wr_col = 3'b100; col_v = 8'h99;
      step();
      lit("rst_pend", regs.rgb[2], m[22], 32'h0099_0000);

      for (int c = 0; c < 3000; c++) begin
         randomize_inputs();
         @(posedge clk);
         #2;
      end
      idle();
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gte_wb_regbank.md
GTE_WB_REGBANK -- requirements
Module: gte_wb_regbank

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 Port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port i_rst, input, 1: reset, synchronous, active-high.
REQ-004 Port i_instrStart, input, 1: first cycle of a GTE instruction; clears FLAG.
REQ-005 Port i_wrMAC0, input, 1, with i_MAC0 [31:0]: MAC0 write.
REQ-006 Port i_wrMAC13, input, 3, with i_MAC13 [31:0]: one-hot MAC1..MAC3 write.
REQ-007 Port i_wrIR0, input, 1, with i_IR0 [15:0]: IR0 write.
REQ-008 Port i_wrIR13, input, 3, with i_IR13 [15:0]: one-hot IR1..IR3 write.
REQ-009 Port i_pushX, input, 1; i_pushY, input, 1; i_XYV, input, 16: screen X/Y push.
REQ-010 Port i_pushZ, input, 1, with i_OTZV [15:0]: SZ FIFO push.
REQ-011 Port i_wrOTZ, input, 1: OTZ <= i_OTZV.
REQ-012 Port i_wrCol, input, 3, with i_colV [7:0]: one-hot R/G/B colour component write.
REQ-013 Port i_CODE, input, 8: CODE byte from RGBC, copied on colour push.
REQ-014 Port i_updateFlags, input, 19: FLAG bits 30..12, OR-accumulated.
REQ-015 Port i_busy, input, 1: instruction in flight; CPU writes ignored while high.
REQ-016 Port i_cpuWr, input, 1, with i_cpuAdr [5:0] and i_cpuData [31:0]: CPU register write (0-31 data regs, 32-63 control regs).
REQ-017 Port i_cpuRd, input, 1, with i_cpuAdr: CPU read request.
REQ-018 Port o_rdData, output, 32: read data.
REQ-019 Port o_rdValid, output, 1: read data valid.
REQ-020 Port o_rdHit, output, 1: the address is owned by this block.
REQ-021 Port o_regs, output, struct: all owned registers in parallel, to the compute path.

Function
REQ-022 Owned registers: OTZ(7), IR0-3(8-11), SXY0-2(12-14), SXYP(15), SZ0-3(16-19), RGB0-2(20-22), MAC0-3(24-27), FLAG(63).
REQ-023 Compute writes SHALL take effect at the clock edge of the strobe; o_regs SHALL show the new value the next cycle.
REQ-024 X push: i_pushX latches i_XYV into a pending-X register; no FIFO change.
REQ-025 Y push: i_pushY shifts SXY0<=SXY1, SXY1<=SXY2, SXY2<={i_XYV, pendingX}.
REQ-026 pushX and pushY in the same cycle: SXY2 SHALL take i_XYV for both halves.
REQ-027 Z push: i_pushZ shifts SZ0<=SZ1<=SZ2<=SZ3, SZ3<=i_OTZV.
REQ-028 Colour: R and G writes go to pending bytes.
REQ-029 The B write SHALL shift RGB0<=RGB1<=RGB2, RGB2<={i_CODE, B, pendG, pendR}.
REQ-030 Colour writes with R, G and B in the same cycle: each component SHALL come from i_colV.
REQ-031 FLAG[30:12] SHALL be cleared when i_instrStart is high, otherwise OR-accumulated with i_updateFlags.
REQ-032 When i_instrStart and i_updateFlags occur in the same cycle, the result SHALL be i_updateFlags only.
REQ-033 FLAG[11:0] SHALL always be 0.
REQ-034 FLAG[31] SHALL be combinational: OR of bits 30:23 and 18:13.
REQ-035 CPU write when i_busy=0 covers these registers: MAC, IR, SZ, OTZ, RGB and SXY0-2.
REQ-036 A CPU write to SXYP SHALL perform a Y-style FIFO shift with the 32-bit data.
REQ-037 A CPU write to FLAG SHALL write bits 30:12 only.
REQ-038 Field widths on CPU write: IR, SZ and OTZ keep bits 15:0; RGB keeps 32 bits.
REQ-039 A CPU write with i_busy=1 SHALL be dropped.
REQ-040 A CPU write and a compute strobe in the same cycle: the compute strobe wins.
REQ-041 CPU read SHALL have a fixed 1-cycle latency: o_rdData and o_rdValid are registered.
REQ-042 o_rdValid=1 for exactly one cycle per i_cpuRd.
REQ-043 o_rdHit=0 and o_rdData=0 for unowned addresses.
REQ-044 Read extension: IR0-3 sign-extended; SZ and OTZ zero-extended.
REQ-045 Reads of SXYP SHALL return SXY2.
REQ-046 A read in the same cycle as a write SHALL return the pre-write value.

Reset
REQ-047 With i_rst high at an edge, the block SHALL reset all registers, pending X/R/G, FLAG, o_rdData and o_rdValid to 0.
REQ-048 Reset mid-instruction SHALL discard all pending bytes.
REQ-049 Reset SHALL override all same-cycle strobes.

Verification
REQ-050 Scenario: reset, then read adr 63 -> o_rdData=0, o_rdValid=1 one cycle later.
REQ-051 Scenario: 4 push pairs X=1..4, Y=0x10..0x13 -> SXY0=0x00110002, SXY2=0x00130004.
REQ-052 Scenario: i_updateFlags bit for FLAG 14 set, then FLAG 22 set -> FLAG=0x80404000.
REQ-053 Scenario: then i_instrStart -> FLAG=0.
REQ-054 Scenario: CPU write IR1=0x0000F000, read -> 0xFFFFF000.
REQ-055 Scenario: CPU write SXYP=0x12345678 -> SXY2=0x12345678, SXY1=old SXY2; read 15 -> 0x12345678.
REQ-056 Scenario: i_busy=1 with CPU write MAC1=5 -> MAC1 unchanged.
REQ-057 Scenario: same-cycle wrMAC13[0] with value 7 and CPU write 5 -> MAC1=7.
REQ-058 Scenario: colour R=0x11, G=0x22, B=0x33, CODE=0x2C -> RGB2=0x2C332211.
REQ-059 Scenario: colour then pushZ 0xFFFF -> SZ3=0xFFFF; read 19 -> 0x0000FFFF.
